// File: rtl/term_pkg.sv
// term_pkg -- shared definitions for the terminal injection queue.
//   * header field offsets, measured down from the packet MSB
//   * default broadcast marker
//   * FSM state type and encodings
//   * hdr_valid(): decides whether a header names a legal mesh target
//                  (broadcast, or a boundary terminal next to the mesh)
package term_pkg;

  localparam logic [7:0] BDCST_DEFAULT = 8'hFF;

  // Field MSB = pckg_sz - <offset>; each coordinate field is 4 bits wide.
  localparam int HDR_BC_OFS  = 1;
  localparam int HDR_ROW_OFS = 9;
  localparam int HDR_COL_OFS = 13;
  localparam int HDR_FLD_W   = 4;

  typedef logic [1:0] state_t;
  localparam state_t ST_EMPTY = 2'd0;  // output register empty
  localparam state_t ST_HOLD  = 2'd1;  // output register valid, queue empty
  localparam state_t ST_QUEUE = 2'd2;  // queue holds at least one packet

  // Terminals sit on a ring just outside the mesh: row 0 / ROWS+1 with a
  // column inside the mesh, or column 0 / COLUMS+1 with a row inside it.
  // Corners and interior nodes are not valid injection targets.
  function automatic logic hdr_valid(
    input logic [7:0] top,
    input logic [3:0] row,
    input logic [3:0] col,
    input logic [7:0] bdcst,
    input int         rows,
    input int         cols
  );
    int   r;
    int   c;
    logic row_edge;
    logic col_edge;
    logic row_in;
    logic col_in;
    r        = {28'd0, row};
    c        = {28'd0, col};
    row_edge = (r == 32'sd0) || (r == rows + 32'sd1);
    col_edge = (c == 32'sd0) || (c == cols + 32'sd1);
    row_in   = (r >= 32'sd1) && (r <= rows);
    col_in   = (c >= 32'sd1) && (c <= cols);
    return (top == bdcst) || (row_edge && col_in) || (col_edge && row_in);
  endfunction

endpackage

// File: rtl/term_inject_if.sv
// term_inject_if -- device/mesh handshake bundle of term_inject.
//   master : device side   (drives push, data_in, popin)
//   slave  : term_inject   (drives full, drop_err, pndng_i_in,
//                           data_out_i_in, count)
interface term_inject_if #(
  parameter int pckg_sz    = 40,
  parameter int fifo_depth = 4
) ();

  localparam int CNT_W = $clog2(fifo_depth + 1);

  logic               push;
  logic [pckg_sz-1:0] data_in;
  logic               full;
  logic               drop_err;
  logic               pndng_i_in;
  logic [pckg_sz-1:0] data_out_i_in;
  logic               popin;
  logic [CNT_W-1:0]   count;

  modport master (
    output push, data_in, popin,
    input  full, drop_err, pndng_i_in, data_out_i_in, count
  );

  modport slave (
    input  push, data_in, popin,
    output full, drop_err, pndng_i_in, data_out_i_in, count
  );

endinterface

// File: rtl/term_fifo.sv
// term_fifo -- circular packet queue behind the output register.
//   clk, reset (async, active-low)
//   push/wr_data : enqueue; honoured when not full, or when full with pop
//   pop/rd_data  : dequeue; rd_data shows the current head combinationally
//   full/empty   : occupancy flags
// Pointers wrap modulo depth, so depth need not be a power of two.
module term_fifo #(
  parameter int pckg_sz = 40,
  parameter int depth   = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               push,
  input  logic               pop,
  input  logic [pckg_sz-1:0] wr_data,
  output logic [pckg_sz-1:0] rd_data,
  output logic               full,
  output logic               empty
);

  localparam int PW = (depth > 1) ? $clog2(depth) : 1;
  localparam int CW = $clog2(depth + 1);
  localparam logic [PW-1:0] PTR_LAST = PW'(depth - 1);
  localparam logic [PW-1:0] PTR_ZERO = {PW{1'b0}};
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [pckg_sz-1:0] mem_q [depth];
  logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               wr_en;
  logic               rd_en;

  assign full    = (cnt_q == CW'(depth));
  assign empty   = (cnt_q == {CW{1'b0}});
  assign wr_en   = push & (~full | pop);
  assign rd_en   = pop & ~empty;
  assign rd_data = mem_q[rd_ptr_q];

  // Next pointer / occupancy values.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (wr_en) begin
      wr_ptr_d = (wr_ptr_q == PTR_LAST) ? PTR_ZERO : wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (rd_en) begin
      rd_ptr_d = (rd_ptr_q == PTR_LAST) ? PTR_ZERO : rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({wr_en, rd_en})
      2'b10:   cnt_d = cnt_q + CNT_ONE;
      2'b01:   cnt_d = cnt_q - CNT_ONE;
      default: cnt_d = cnt_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= PTR_ZERO;
      rd_ptr_q <= PTR_ZERO;
      cnt_q    <= {CW{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage array; contents are only observed while the queue is non-empty.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

endmodule

// File: rtl/term_inject.sv
// term_inject -- terminal-to-mesh injection queue.
//   clk    : sole clock, rising edge
//   reset  : asynchronous, active-low
//   bus    : term_inject_if.slave (push/data_in in, popin in,
//            full/drop_err/pndng_i_in/data_out_i_in/count out)
// Packets with a legal target header are held in strict FIFO order: the
// head lives in a registered output stage, the rest in term_fifo.
// Optional build macro TERM_INJECT_STATS_EN adds saturating 16-bit
// sent_cnt / drop_cnt outputs.
module term_inject
  import term_pkg::*;
#(
  parameter int         pckg_sz    = 40,
  parameter int         fifo_depth = 4,
  parameter int         ROWS       = 4,
  parameter int         COLUMS     = 4,
  parameter logic [7:0] bdcst      = BDCST_DEFAULT
) (
  input  logic  clk,
  input  logic  reset,
  term_inject_if.slave bus
`ifdef TERM_INJECT_STATS_EN
  ,
  output logic [15:0] sent_cnt,
  output logic [15:0] drop_cnt
`endif
);

  localparam int CNT_W = $clog2(fifo_depth + 1);
  localparam int FD    = fifo_depth - 1;
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_TWO  = CNT_W'(2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(fifo_depth);

  state_t             state_q, state_d;
  logic               pndng_q, pndng_d;
  logic [pckg_sz-1:0] data_q, data_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               drop_q, drop_d;

  logic               hdr_ok;
  logic               full_s;
  logic               pop_eff;
  logic               push_ok;
  logic               fifo_push;
  logic               fifo_pop;
  logic [pckg_sz-1:0] fifo_rd;
  logic               fifo_full;
  logic               fifo_empty;

  assign hdr_ok = hdr_valid(bus.data_in[pckg_sz-HDR_BC_OFS  -: 8],
                            bus.data_in[pckg_sz-HDR_ROW_OFS -: HDR_FLD_W],
                            bus.data_in[pckg_sz-HDR_COL_OFS -: HDR_FLD_W],
                            bdcst, ROWS, COLUMS);

  assign full_s  = (count_q == CNT_FULL);
  assign pop_eff = bus.popin & pndng_q;
  // A pop in the same cycle frees a slot, so a full queue can still accept.
  assign push_ok = bus.push & hdr_ok & (~full_s | pop_eff);

  term_fifo #(
    .pckg_sz (pckg_sz),
    .depth   (FD)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (fifo_push),
    .pop     (fifo_pop),
    .wr_data (bus.data_in),
    .rd_data (fifo_rd),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Queue control FSM: steers pushes to the output register or the FIFO.
  always_comb begin
    state_d   = state_q;
    pndng_d   = pndng_q;
    data_d    = data_q;
    count_d   = count_q;
    fifo_push = 1'b0;
    fifo_pop  = 1'b0;
    drop_d    = bus.push & ~push_ok;
    case (state_q)
      ST_EMPTY: begin
        if (push_ok) begin
          pndng_d = 1'b1;
          data_d  = bus.data_in;
          count_d = CNT_ONE;
          state_d = ST_HOLD;
        end else begin
          state_d = ST_EMPTY;
        end
      end
      ST_HOLD: begin
        if (push_ok && pop_eff) begin
          // Head leaves and the new packet replaces it directly.
          data_d = bus.data_in;
        end else if (push_ok) begin
          fifo_push = 1'b1;
          count_d   = count_q + CNT_ONE;
          state_d   = ST_QUEUE;
        end else if (pop_eff) begin
          pndng_d = 1'b0;
          count_d = CNT_ZERO;
          state_d = ST_EMPTY;
        end else begin
          state_d = ST_HOLD;
        end
      end
      ST_QUEUE: begin
        if (pop_eff) begin
          data_d   = fifo_rd;
          fifo_pop = 1'b1;
        end else begin
          data_d = data_q;
        end
        fifo_push = push_ok;
        if (push_ok && !pop_eff) begin
          count_d = count_q + CNT_ONE;
        end else if (!push_ok && pop_eff) begin
          count_d = count_q - CNT_ONE;
          // Last queued packet moved into the output register.
          state_d = (count_q == CNT_TWO) ? ST_HOLD : ST_QUEUE;
        end else begin
          count_d = count_q;
        end
      end
      default: begin
        state_d = ST_EMPTY;
        pndng_d = 1'b0;
        count_d = CNT_ZERO;
      end
    endcase
  end

  // State, output register and status flops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_EMPTY;
      pndng_q <= 1'b0;
      data_q  <= {pckg_sz{1'b0}};
      count_q <= CNT_ZERO;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pndng_q <= pndng_d;
      data_q  <= data_d;
      count_q <= count_d;
      drop_q  <= drop_d;
    end
  end

  assign bus.full          = full_s;
  assign bus.drop_err      = drop_q;
  assign bus.pndng_i_in    = pndng_q;
  assign bus.data_out_i_in = data_q;
  assign bus.count         = count_q;

`ifdef TERM_INJECT_STATS_EN
  logic [15:0] sent_q, sent_d;
  logic [15:0] dcnt_q, dcnt_d;

  // Saturating event counters.
  always_comb begin
    sent_d = sent_q;
    dcnt_d = dcnt_q;
    if (pop_eff && (sent_q != 16'hFFFF)) begin
      sent_d = sent_q + 16'd1;
    end else begin
      sent_d = sent_q;
    end
    if (drop_d && (dcnt_q != 16'hFFFF)) begin
      dcnt_d = dcnt_q + 16'd1;
    end else begin
      dcnt_d = dcnt_q;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sent_q <= 16'd0;
      dcnt_q <= 16'd0;
    end else begin
      sent_q <= sent_d;
      dcnt_q <= dcnt_d;
    end
  end

  assign sent_cnt = sent_q;
  assign drop_cnt = dcnt_q;
`endif

  // fifo_full / fifo_empty are implied by the FSM state and count.
  logic unused_s;
  assign unused_s = fifo_full ^ fifo_empty;

endmodule
